// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with stall, flush, back-pressure and packed raw immediate.
// Optional build macro IF_ID_ILLEGAL_EN adds a registered out_illegal flag.
module if_id_stage #(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [31:0]     out_imm_field
`ifdef IF_ID_ILLEGAL_EN
  ,
  output logic            out_illegal
`endif
);

  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_I_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_S_TYPE = 7'b0100011;
  localparam logic [6:0] OP_B_TYPE = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            load;

  // Flush forces ready so fetch never waits on a redirect cycle.
  always_comb begin
    in_ready = (!stall && (!valid_q || out_ready)) || flush;
    load     = in_valid && in_ready && !flush;
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (stall) begin
      valid_d = valid_q;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    out_valid  = valid_q;
    out_instr  = instr_q;
    out_pc     = pc_q;
    out_opcode = instr_q[6:0];
  end

  // Raw fields only; sign extension happens downstream.
  always_comb begin
    out_imm_field = '0;
    unique case (instr_q[6:0])
      OP_I_TYPE, OP_I_LOAD, OP_JALR:
        out_imm_field = {20'b0, instr_q[31:20]};
      OP_S_TYPE:
        out_imm_field = {20'b0, instr_q[31:25], instr_q[11:7]};
      OP_B_TYPE:
        out_imm_field = {20'b0, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8]};
      OP_JAL:
        out_imm_field = {12'b0, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21]};
      OP_AUIPC, OP_LUI:
        out_imm_field = {12'b0, instr_q[31:12]};
      default:
        out_imm_field = '0;
    endcase
  end

`ifdef IF_ID_ILLEGAL_EN
  logic illegal_q, illegal_d, in_illegal;

  always_comb begin
    unique case (in_instr[6:0])
      OP_I_TYPE, OP_I_LOAD, OP_JALR, OP_S_TYPE, OP_B_TYPE,
      OP_JAL, OP_AUIPC, OP_LUI, OP_R_TYPE: in_illegal = 1'b0;
      default:                             in_illegal = 1'b1;
    endcase
  end

  always_comb begin
    illegal_d = illegal_q;
    if (flush)      illegal_d = 1'b0;
    else if (stall) illegal_d = illegal_q;
    else if (load)  illegal_d = in_illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign out_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage with a behavioural reference model.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [31:0] out_imm_field;

  int pass_cnt = 0;
  int total_cnt = 0;

  if_id_stage #(.PC_W(32), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_imm_field(out_imm_field)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Immediate reconstructed as the branch/jump byte offset, then halved.
  function automatic logic [31:0] model_imm(input logic [31:0] i);
    logic [12:0] boff;
    logic [20:0] joff;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: model_imm = i >> 20;
      7'h23: model_imm = ((i >> 25) << 5) | ((i >> 7) & 32'h1F);
      7'h63: begin
        boff = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        model_imm = 32'(boff) >> 1;
      end
      7'h6F: begin
        joff = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        model_imm = 32'(joff) >> 1;
      end
      7'h17, 7'h37: model_imm = i >> 12;
      default: model_imm = 32'h0;
    endcase
  endfunction

  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_instr <= 32'h13;
      m_pc    <= 32'h0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_instr <= 32'h13;
    end else if (!stall) begin
      if (in_valid && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        m_instr <= in_instr;
        m_pc    <= in_pc;
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_in_ready", {31'b0, in_ready}, {31'b0, flush || (!stall && (!m_valid || out_ready))});
    check("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("cyc_out_instr", out_instr, m_instr);
    check("cyc_out_opcode", {25'b0, out_opcode}, m_instr & 32'h7F);
    check("cyc_out_imm", out_imm_field, model_imm(m_instr));
    if (m_valid) check("cyc_out_pc", out_pc, m_pc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
  endtask

  initial begin
    #12;
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_instr", out_instr, 32'h0000_0013);
    check("rst_opcode", {25'b0, out_opcode}, 32'h13);
    check("rst_imm", out_imm_field, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    rst_n = 1'b1;
    tick();

    // addi x1,x0,-1
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF0_0093, 32'h100);
    tick();
    check("addi_valid", {31'b0, out_valid}, 32'h1);
    check("addi_pc", out_pc, 32'h100);
    check("addi_opcode", {25'b0, out_opcode}, 32'h13);
    check("addi_imm", out_imm_field, 32'h0000_0FFF);

    // sw then jal -8, back to back
    drive(1'b1, 32'hFE20_AE23, 32'h104);
    tick();
    check("sw_imm", out_imm_field, 32'h0000_0FFC);
    check("sw_valid", {31'b0, out_valid}, 32'h1);
    drive(1'b1, 32'hFF9F_F06F, 32'h108);
    tick();
    check("jal_imm", out_imm_field, 32'h000F_FFFC);
    check("jal_valid", {31'b0, out_valid}, 32'h1);
    check("jal_pc", out_pc, 32'h108);

    // back-pressure
    out_ready = 1'b0;
    drive(1'b1, 32'h1234_5037, 32'h10C);
    #1;
    check("bp_in_ready", {31'b0, in_ready}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_instr", out_instr, 32'hFF9F_F06F);
      check("bp_hold_valid", {31'b0, out_valid}, 32'h1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, in_ready}, 32'h1);
    tick();
    check("lui_instr", out_instr, 32'h1234_5037);
    check("lui_imm", out_imm_field, 32'h0001_2345);
    check("lui_pc", out_pc, 32'h10C);

    // flush + stall with valid incoming
    flush = 1'b1;
    stall = 1'b1;
    drive(1'b1, 32'h0000_0063, 32'h110);
    #1;
    check("flush_in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    check("flush_valid", {31'b0, out_valid}, 32'h0);
    check("flush_instr", out_instr, 32'h0000_0013);
    flush = 1'b0;

    // stall alone holds
    drive(1'b1, 32'hFE00_0EE3, 32'h200);
    tick();
    check("stall_no_load", {31'b0, out_valid}, 32'h0);
    stall = 1'b0;
    tick();
    check("beq_imm", out_imm_field, 32'h0000_0FFE);
    check("beq_valid", {31'b0, out_valid}, 32'h1);

    // drain keeps data
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("drain_valid", {31'b0, out_valid}, 32'h0);
    check("drain_instr", out_instr, 32'hFE00_0EE3);

    // R-type gives zero field; then asynchronous reset mid-cycle
    drive(1'b1, 32'h0020_80B3, 32'h300);
    tick();
    check("rtype_imm", out_imm_field, 32'h0);
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b0;
    tick();
    check("pre_async_valid", {31'b0, out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'h0);
    check("async_rst_instr", out_instr, 32'h0000_0013);
    check("async_rst_pc", out_pc, 32'h0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_1117, 32'h400);
    tick();
    check("auipc_imm", out_imm_field, 32'h0000_0001);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
